// File: rtl/my_micro_sequencer.sv
// Program sequencer for my_micro: 16-word program store, one fetch per cycle,
// jump/conditional branch on flag_cmp, halt/stop, and a run watchdog.
//
//  state  | meaning
//  IDLE   | after reset; store writable, waiting for start
//  RUN    | fetching/decoding one word per cycle
//  HALT   | stopped by HALT word, stop or watchdog; store writable, start re-runs
module my_micro_sequencer #(
    parameter int         DEPTH      = 16,
    parameter logic [7:0] NOP_INSTR  = 8'h30,
    parameter int         MAX_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        prog_we,
    input  logic [3:0]  prog_addr,
    input  logic [11:0] prog_data,
    input  logic        start,
    input  logic        stop,
    input  logic [2:0]  flag_cmp,
    output logic [7:0]  instruction,
    output logic [3:0]  pc,
    output logic        busy,
    output logic        halted,
    output logic        timeout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALT
    } state_t;

    localparam logic [3:0] C_JMP  = 4'b0001;
    localparam logic [3:0] C_JGT  = 4'b0010;
    localparam logic [3:0] C_JEQ  = 4'b0011;
    localparam logic [3:0] C_JLT  = 4'b0100;
    localparam logic [3:0] C_HALT = 4'b1111;
    localparam logic [7:0] WD_LAST = 8'(MAX_CYCLES - 1);

    state_t      state;
    logic [11:0] mem [DEPTH];
    logic [7:0]  cycle_cnt;

    logic [11:0] word;
    logic [3:0]  ctrl;
    logic        is_branch;
    logic        branch_hit;
    logic        cm_pending;

    always_comb begin
        word       = mem[pc];
        ctrl       = word[11:8];
        is_branch  = 1'b0;
        branch_hit = 1'b0;
        case (ctrl)
            C_JGT: begin is_branch = 1'b1; branch_hit = flag_cmp[2]; end
            C_JEQ: begin is_branch = 1'b1; branch_hit = flag_cmp[1]; end
            C_JLT: begin is_branch = 1'b1; branch_hit = flag_cmp[0]; end
            default: ;
        endcase
        // flag_cmp is stale while a compare (CM/CMI) sits on the instruction bus
        cm_pending = (instruction[7:4] == 4'h7) || (instruction[7:4] == 4'hF);
    end

    assign busy   = (state == S_RUN);
    assign halted = (state == S_HALT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            pc          <= 4'd0;
            instruction <= NOP_INSTR;
            timeout     <= 1'b0;
            cycle_cnt   <= 8'd0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= 12'h000;
        end else begin
            instruction <= NOP_INSTR;
            case (state)
                S_IDLE, S_HALT: begin
                    if (prog_we) mem[prog_addr] <= prog_data;
                    if (start) begin
                        state     <= S_RUN;
                        pc        <= 4'd0;
                        cycle_cnt <= 8'd0;
                        timeout   <= 1'b0;
                    end
                end
                S_RUN: begin
                    cycle_cnt <= cycle_cnt + 8'd1;
                    if (stop) begin
                        state <= S_HALT;
                    end else if (cycle_cnt == WD_LAST) begin
                        state   <= S_HALT;
                        timeout <= 1'b1;
                    end else if (ctrl == C_HALT) begin
                        state <= S_HALT;
                    end else if (ctrl == C_JMP) begin
                        pc <= word[3:0];
                    end else if (is_branch) begin
                        if (!cm_pending) pc <= branch_hit ? word[3:0] : pc + 4'd1;
                    end else begin
                        instruction <= word[7:0];
                        pc          <= pc + 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
